// File: rtl/rl_pi_ctrl_if.sv
// Sample/result handshake bundle for the PI current controller.
// The master drives the current samples and result acceptance; the slave is the controller.
interface rl_pi_ctrl_if;
  logic signed [31:0] i_ref;
  logic signed [31:0] i_meas;
  logic               in_valid;
  logic               in_ready;
  logic               integ_clr;
  logic signed [15:0] u_cmd;
  logic               out_valid;
  logic               out_ready;
  logic               sat;

  modport master (
    output i_ref, i_meas, in_valid, integ_clr, out_ready,
    input  in_ready, u_cmd, out_valid, sat
  );

  modport slave (
    input  i_ref, i_meas, in_valid, integ_clr, out_ready,
    output in_ready, u_cmd, out_valid, sat
  );
endinterface

// File: rtl/rl_pi_ctrl.sv
// Sequential PI current controller: one pipeline step per state, clamped Q0 voltage output.
// Optional macro RL_PI_ANTIWINDUP_EN freezes the integrator while pushing further into saturation.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// ERR   | err = i_ref - i_meas
// PROD  | p = KP*err, k = KI*err
// ACC   | integrator update (clear / saturating add / hold)
// SUM   | s = (p + integ) >>> 8
// SAT   | clamp s into u_cmd, raise out_valid
// OUT   | hold result until out_ready
module rl_pi_ctrl #(
  parameter int signed KP    = 4,
  parameter int signed KI    = 1,
  parameter int signed U_MAX = 200,
  parameter int signed U_MIN = -200
) (
  input  logic         clk,
  input  logic         rst,
  rl_pi_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    PROD = 3'd2,
    ACC  = 3'd3,
    SUM  = 3'd4,
    SAT  = 3'd5,
    OUT  = 3'd6
  } state_t;

  localparam logic signed [47:0] INTEG_POS_LIM = {1'b0, {47{1'b1}}};
  localparam logic signed [47:0] INTEG_NEG_LIM = {1'b1, {47{1'b0}}};

  state_t             state_q, state_d;
  logic signed [31:0] ref_q, ref_d;
  logic signed [31:0] meas_q, meas_d;
  logic               clr_q, clr_d;
  logic signed [32:0] err_q, err_d;
  logic signed [47:0] p_q, p_d;
  logic signed [47:0] k_q, k_d;
  logic signed [47:0] integ_q, integ_d;
  logic signed [47:0] s_q, s_d;
  logic signed [15:0] u_q, u_d;
  logic               sat_q, sat_d;
  logic               ov_q, ov_d;
  logic signed [48:0] acc_sum;
  logic               integ_hold;
`ifdef RL_PI_ANTIWINDUP_EN
  logic               sat_hi_q, sat_hi_d;
  logic               sat_lo_q, sat_lo_d;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.u_cmd     = u_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = ov_q;

  always_comb begin
    acc_sum = 49'(integ_q) + 49'(k_q);
`ifdef RL_PI_ANTIWINDUP_EN
    // Flags come from the previous result, so a wound-up integrator stops growing.
    integ_hold = (sat_hi_q && (err_q > 33'sd0)) || (sat_lo_q && (err_q < 33'sd0));
`else
    integ_hold = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    meas_d  = meas_q;
    clr_d   = clr_q;
    err_d   = err_q;
    p_d     = p_q;
    k_d     = k_q;
    integ_d = integ_q;
    s_d     = s_q;
    u_d     = u_q;
    sat_d   = sat_q;
    ov_d    = ov_q;
`ifdef RL_PI_ANTIWINDUP_EN
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ref_d   = bus.i_ref;
          meas_d  = bus.i_meas;
          clr_d   = bus.integ_clr;
          state_d = ERR;
        end
      end
      ERR: begin
        err_d   = 33'(ref_q) - 33'(meas_q);
        state_d = PROD;
      end
      PROD: begin
        p_d     = 48'(err_q) * 48'(KP);
        k_d     = 48'(err_q) * 48'(KI);
        state_d = ACC;
      end
      ACC: begin
        if (clr_q) begin
          integ_d = '0;
        end else if (!integ_hold) begin
          if (acc_sum[48] != acc_sum[47]) begin
            integ_d = acc_sum[48] ? INTEG_NEG_LIM : INTEG_POS_LIM;
          end else begin
            integ_d = acc_sum[47:0];
          end
        end
        state_d = SUM;
      end
      SUM: begin
        s_d     = (p_q + integ_q) >>> 8;
        state_d = SAT;
      end
      SAT: begin
        if (s_q > 48'(U_MAX)) begin
          u_d   = 16'(U_MAX);
          sat_d = 1'b1;
        end else if (s_q < 48'(U_MIN)) begin
          u_d   = 16'(U_MIN);
          sat_d = 1'b1;
        end else begin
          u_d   = s_q[15:0];
          sat_d = 1'b0;
        end
`ifdef RL_PI_ANTIWINDUP_EN
        sat_hi_d = (s_q > 48'(U_MAX));
        sat_lo_d = (s_q < 48'(U_MIN));
`endif
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ref_q   <= '0;
      meas_q  <= '0;
      clr_q   <= 1'b0;
      err_q   <= '0;
      p_q     <= '0;
      k_q     <= '0;
      integ_q <= '0;
      s_q     <= '0;
      u_q     <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
`ifdef RL_PI_ANTIWINDUP_EN
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      meas_q  <= meas_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      p_q     <= p_d;
      k_q     <= k_d;
      integ_q <= integ_d;
      s_q     <= s_d;
      u_q     <= u_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
`ifdef RL_PI_ANTIWINDUP_EN
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_rl_pi_ctrl.sv
// Self-checking bench for rl_pi_ctrl: arithmetic reference model plus literal anchors.
// Builds with or without RL_PI_ANTIWINDUP_EN; the model follows the same macro.
module tb_rl_pi_ctrl;
  localparam int KP    = 4;
  localparam int KI    = 1;
  localparam int U_MAX = 200;
  localparam int U_MIN = -200;
`ifdef RL_PI_ANTIWINDUP_EN
  localparam bit AW = 1'b1;
`else
  localparam bit AW = 1'b0;
`endif
  localparam longint ILIM_P = 64'sd140737488355327;
  localparam longint ILIM_N = -64'sd140737488355328;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rl_pi_ctrl_if bus ();

  rl_pi_ctrl #(.KP(KP), .KI(KI), .U_MAX(U_MAX), .U_MIN(U_MIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int u;
    bit s;
    int due;
  } exp_t;

  exp_t   exp_q[$];
  int     n_pass = 0;
  int     n_total = 0;
  int     cyc = 0;
  bit     m_busy = 1'b0;
  int     held_u = 0;
  bit     held_sat = 1'b0;
  bit     prev_ov = 1'b0;
  longint m_integ = 0;
  bit     m_hi = 1'b0;
  bit     m_lo = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain integer arithmetic with floor division for the >>> 8.
  task automatic model(input longint r, input longint m, input bit clr,
                       output int u, output bit s);
    longint err, p, k, x, sv;
    bit hold;
    err  = r - m;
    p    = KP * err;
    k    = KI * err;
    hold = AW && ((m_hi && err > 0) || (m_lo && err < 0));
    if (clr) m_integ = 0;
    else if (!hold) begin
      m_integ = m_integ + k;
      if (m_integ > ILIM_P) m_integ = ILIM_P;
      if (m_integ < ILIM_N) m_integ = ILIM_N;
    end
    x = p + m_integ;
    if (x >= 0) sv = x / 256;
    else sv = -((-x + 255) / 256);
    m_hi = (sv > U_MAX);
    m_lo = (sv < U_MIN);
    if (m_hi) u = U_MAX;
    else if (m_lo) u = U_MIN;
    else u = int'(sv);
    s = m_hi || m_lo;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() > 0) begin
        held_u   = exp_q[0].u;
        held_sat = exp_q[0].s;
        void'(exp_q.pop_front());
      end
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_u_cmd", bus.u_cmd, 0);
      chk("rst_sat", bus.sat, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      held_u   = 0;
      held_sat = 1'b0;
      prev_ov  = 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, !m_busy);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", bus.out_valid, 0);
        else begin
          if (!prev_ov) chk("out_valid_latency", cyc, exp_q[0].due);
          chk("u_cmd", bus.u_cmd, exp_q[0].u);
          chk("sat", bus.sat, exp_q[0].s);
        end
      end else begin
        chk("u_cmd_hold", bus.u_cmd, held_u);
        chk("sat_hold", bus.sat, held_sat);
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic accept(input int r, input int m, input bit clr);
    exp_t e;
    int w;
    bus.i_ref     = r;
    bus.i_meas    = m;
    bus.integ_clr = clr;
    bus.in_valid  = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1);
    model(r, m, clr, e.u, e.s);
    e.due = cyc + 6;
    exp_q.push_back(e);
    @(posedge clk);
    m_busy = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.integ_clr = 1'b0;
  endtask

  task automatic sample(input int r, input int m, input bit clr, input int hold,
                        input bit lit_en, input int lit_u, input bit lit_sat);
    int w;
    accept(r, m, clr);
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) chk("result_timeout", bus.out_valid, 1);
    if (lit_en) begin
      chk("lit_u_cmd", bus.u_cmd, lit_u);
      chk("lit_sat", bus.sat, lit_sat);
    end
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // Entered at a negedge; asserts reset asynchronously a little later.
  task automatic pulse_reset(input int cycles);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_u_cmd", bus.u_cmd, 0);
    chk("async_rst_sat", bus.sat, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    exp_q.delete();
    m_integ  = 0;
    m_hi     = 1'b0;
    m_lo     = 1'b0;
    m_busy   = 1'b0;
    held_u   = 0;
    held_sat = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("first_in_ready", bus.in_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_ref     = 0;
    bus.i_meas    = 0;
    bus.in_valid  = 1'b0;
    bus.integ_clr = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("first_in_ready", bus.in_ready, 1);
    @(negedge clk);

    sample(256, 0, 1'b0, 0, 1'b1, 5, 1'b0);
    sample(256, 0, 1'b0, 0, 1'b1, 6, 1'b0);
    sample(0, 0, 1'b1, 0, 1'b1, 0, 1'b0);
    sample(0, 256, 1'b0, 0, 1'b1, -5, 1'b0);

    sample(0, 0, 1'b1, 0, 1'b1, 0, 1'b0);
    sample(25600, 0, 1'b0, 0, 1'b1, 200, 1'b1);
    sample(-25600, 0, 1'b0, 0, 1'b1, -200, 1'b1);

    sample(0, 0, 1'b1, 0, 1'b1, 0, 1'b0);
    sample(25600, 0, 1'b0, 0, 1'b1, 200, 1'b1);
    sample(25600, 0, 1'b0, 0, 1'b1, 200, 1'b1);
    sample(25600, 0, 1'b0, 0, 1'b1, 200, 1'b1);
    if (AW) sample(0, 256, 1'b0, 0, 1'b1, 95, 1'b0);
    else sample(0, 256, 1'b0, 0, 1'b1, 200, 1'b1);

    sample(512, 256, 1'b1, 10, 1'b1, 4, 1'b0);

    // Abort a sample while it sits in PROD.
    accept(256, 0, 1'b0);
    @(negedge clk);
    pulse_reset(2);
    repeat (10) begin
      @(negedge clk);
      chk("no_out_after_abort", bus.out_valid, 0);
    end
    sample(256, 0, 1'b0, 0, 1'b1, 5, 1'b0);

    sample(-1000, 333, 1'b0, 0, 1'b0, 0, 1'b0);
    sample(7, 3, 1'b0, 2, 1'b0, 0, 1'b0);
    sample(100000, -100000, 1'b0, 0, 1'b0, 0, 1'b0);
    sample(-300, 0, 1'b1, 1, 1'b0, 0, 1'b0);
    sample(-40000, 1000, 1'b0, 0, 1'b0, 0, 1'b0);
    sample(1, 0, 1'b0, 0, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rl_pi_ctrl.md
RL_PI_CTRL -- requirements
Module: rl_pi_ctrl

Interface
REQ-001 Parameter KP, default 4, signed proportional gain, Q0.
REQ-002 Parameter KI, default 1, signed integral gain per sample, Q0.
REQ-003 Parameter U_MAX, default 200, signed upper voltage limit, Q0.
REQ-004 Parameter U_MIN, default -200, signed lower voltage limit, Q0.
REQ-005 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port i_ref, input, 32, signed current setpoint, Q8.
REQ-008 Port i_meas, input, 32, signed measured or plant-model current, Q8.
REQ-009 Port in_valid / in_ready, input / output, 1 each, sample handshake.
REQ-010 Port integ_clr, input, 1, clears integrator when sampled with an accepted input.
REQ-011 Port u_cmd, output, 16, signed voltage command, Q0, registered.
REQ-012 Port out_valid / out_ready, output / input, 1 each, result handshake.
REQ-013 Port sat, output, 1, u_cmd was clamped on the current result.

Function
REQ-014 FSM states: IDLE, ERR, PROD, ACC, SUM, SAT, OUT; one state per clock, no skips.
REQ-015 in_ready SHALL be high only in IDLE, combinationally from state.
REQ-016 IDLE: on in_valid&&in_ready, register i_ref, i_meas, integ_clr; go to ERR.
REQ-017 ERR: err = i_ref - i_meas, 33-bit signed.
REQ-018 PROD: p = KP*err and k = KI*err, both 48-bit signed products.
REQ-019 ACC: integ (48-bit signed) = 0 if captured integ_clr, else integ + k, saturating at the 48-bit signed limits; no wrap.
REQ-020 SUM: s = (p + integ) >>> 8, arithmetic shift, 48-bit signed, truncation toward minus infinity.
REQ-021 SAT: u_cmd = clamp(s, U_MIN, U_MAX); sat = 1 if clamped; sat_hi/sat_lo record the clamp direction; out_valid set; go to OUT.
REQ-022 out_valid SHALL rise exactly 5 cycles after the input-accept edge.
REQ-023 OUT: u_cmd, sat, out_valid hold until out_valid&&out_ready; then out_valid clears and FSM returns to IDLE.
REQ-024 Next input SHALL NOT be accepted in the same cycle as the output handshake; minimum sample period is 7 cycles.
REQ-025 u_cmd and sat SHALL change only in SAT; otherwise they hold the last result.

Reset
REQ-026 rst low SHALL immediately force IDLE, u_cmd=0, sat=0, sat_hi=sat_lo=0, out_valid=0, integ=0 and clear all pipeline registers.
REQ-027 Reset mid-computation SHALL discard the sample with no partial output.
REQ-028 After rst deasserts, in_ready SHALL be high on the first cycle.

Configuration
REQ-029 Macro RL_PI_ANTIWINDUP_EN defined: in ACC, integ holds (k not added) if sat_hi and err>0 or sat_lo and err<0, using the previous result's flags; integ_clr still takes priority.
REQ-030 Macro RL_PI_ANTIWINDUP_EN undefined: integ always updates per REQ-019; sat_hi/sat_lo are unused.

Verification
REQ-031 Defaults, i_ref=256, i_meas=0, one sample -> u_cmd=5, sat=0, out_valid 5 cycles after accept.
REQ-032 Repeat the same sample -> u_cmd=6 (integ=512); then i_ref=0, i_meas=256 after integ_clr -> u_cmd=-5.
REQ-033 i_ref=25600, i_meas=0 -> u_cmd=200, sat=1; i_ref=-25600 -> u_cmd=-200, sat=1.
REQ-034 With RL_PI_ANTIWINDUP_EN, three saturating samples (25600) then err=-256 -> integ stays 25600 after the first sample, so recovery is faster than the same bench without the macro, where integ=76800.
REQ-035 out_ready held low 10 cycles in OUT -> u_cmd, sat, out_valid stable and in_ready low throughout; release -> one handshake, then IDLE.
REQ-036 rst pulsed low during PROD -> outputs zero at once, no out_valid, the next sample computes from integ=0.
